// File: rtl/rvx_dispatch_writeback.sv
// rvx_dispatch_writeback: single-issue dispatch/writeback stage for the extended execute core, with optional DISPATCH_PERF_EN perf counters
module rvx_dispatch_writeback #(
  parameter logic [6:0] CUSTOM_OPCODE = 7'h0B,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input logic clk,
  input logic rst,
  input logic instr_valid,
  output logic instr_ready,
  input logic [31:0] instr,
  input logic [31:0] rs1_data,
  input logic [31:0] rs2_data,
  output logic ex_valid_in,
  output logic [2:0] ex_funct3,
  output logic [6:0] ex_funct7,
  output logic [31:0] ex_rs1,
  output logic [31:0] ex_rs2,
  output logic [31:0] ex_addr,
  output logic [2:0] ex_mode,
  output logic ex_aq,
  output logic ex_rl,
  input logic ex_valid_out,
  input logic [31:0] ex_result,
  output logic wb_en,
  output logic [4:0] wb_rd,
  output logic [31:0] wb_data,
  output logic busy,
  output logic illegal_instr,
  output logic timeout_err
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_wait
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [2:0] funct3_q, funct3_d;
  logic [6:0] funct7_q, funct7_d;
  logic [4:0] rd_q, rd_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, timeout_q, timeout_d;
  logic fire, legal, done, unused;
  assign unused = ^instr[24:15];
  assign fire = instr_valid && state_q == IDLE;
  assign legal = instr[6:0] == CUSTOM_OPCODE;
  assign done = state_q == WAIT && ex_valid_out;
  always_comb begin
    funct3_d = fire ? instr[14:12] : funct3_q;
    funct7_d = fire ? instr[31:25] : funct7_q;
    rd_d = fire ? instr[11:7] : rd_q;
    rs1_d = fire ? rs1_data : rs1_q;
    rs2_d = fire ? rs2_data : rs2_q;
    res_d = done ? ex_result : res_q;
    illegal_d = fire && !legal;
    timeout_d = state_q == WAIT && !ex_valid_out && cnt_q == LIMIT;
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    state_d = state_q == IDLE  ? (fire && legal ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (ex_valid_out ? WB : timeout_d ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      funct3_q <= '0;
      funct7_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      rd_q <= rd_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end
  assign instr_ready = state_q == IDLE;
  assign busy = !instr_ready;
  assign ex_valid_in = state_q == ISSUE;
  assign ex_funct3 = busy ? funct3_q : '0;
  assign ex_funct7 = busy ? funct7_q : '0;
  assign ex_rs1 = busy ? rs1_q : '0;
  assign ex_rs2 = busy ? rs2_q : '0;
  assign ex_addr = busy ? rs1_q : '0;
  assign ex_mode = busy ? funct7_q[6:4] : '0;
  assign ex_aq = busy && funct7_q[1];
  assign ex_rl = busy && funct7_q[0];
  assign wb_en = state_q == WB && rd_q != '0;
  assign wb_rd = state_q == WB ? rd_q : '0;
  assign wb_data = state_q == WB ? res_q : '0;
  assign illegal_instr = illegal_q;
  assign timeout_err = timeout_q;
`ifdef DISPATCH_PERF_EN
  logic [31:0] ops_q, ops_d, wait_q, wait_d;
  always_comb begin
    ops_d = ops_q + 32'(state_q == WB);
    wait_d = wait_q + 32'(state_q == WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q <= '0;
      wait_q <= '0;
    end else begin
      ops_q <= ops_d;
      wait_q <= wait_d;
    end
  end
  assign perf_ops = ops_q;
  assign perf_wait = wait_q;
`endif
endmodule

// File: tb/tb_rvx_dispatch_writeback.sv
// tb_rvx_dispatch_writeback: table-driven directed bench for rvx_dispatch_writeback
module tb_rvx_dispatch_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic ex_valid_in;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic [31:0] ex_rs1, ex_rs2, ex_addr;
  logic [2:0] ex_mode;
  logic ex_aq, ex_rl;
  logic ex_valid_out = 1'b0;
  logic [31:0] ex_result = '0;
  logic wb_en;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic busy, illegal_instr, timeout_err;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_ops, perf_wait;
`endif
  rvx_dispatch_writeback dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .ex_valid_in(ex_valid_in),
    .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7),
    .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2),
    .ex_addr(ex_addr),
    .ex_mode(ex_mode),
    .ex_aq(ex_aq),
    .ex_rl(ex_rl),
    .ex_valid_out(ex_valid_out),
    .ex_result(ex_result),
    .wb_en(wb_en),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .busy(busy),
    .illegal_instr(illegal_instr),
    .timeout_err(timeout_err)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_ops(perf_ops),
    .perf_wait(perf_wait)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr, rs1, rs2, res;
    int delay;
    logic early;
    int e_issue, e_wb;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    int e_ill, e_tmo, e_idle;
    logic [14:0] e_ex;
  } vec_t;
  vec_t v[7];
  int checks = 0;
  int errors = 0;
  int o_issue, o_wb, o_ill, o_tmo, o_idle, o_stray, o_hold;
  logic [4:0] o_rd;
  logic [31:0] o_data, o_addr, o_rs1, o_rs2;
  logic [14:0] o_ex;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic quiet_bad();
    return ex_valid_in || wb_en || busy || illegal_instr || timeout_err || !instr_ready ||
           |{ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_addr, ex_mode, ex_aq, ex_rl, wb_rd, wb_data};
  endfunction
  task automatic run_op(input vec_t t);
    o_issue = 0; o_wb = 0; o_ill = 0; o_tmo = 0; o_idle = 0; o_stray = 0; o_hold = 0;
    o_rd = '0; o_data = '0; o_addr = '0; o_rs1 = '0; o_rs2 = '0; o_ex = '0;
    @(negedge clk);
    instr_valid = 1'b1; instr = t.instr; rs1_data = t.rs1; rs2_data = t.rs2;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    for (int k = 1; k <= 200; k++) begin
      if (ex_valid_in) begin
        o_issue++;
        o_ex = {ex_funct3, ex_funct7, ex_mode, ex_aq, ex_rl};
        o_addr = ex_addr; o_rs1 = ex_rs1; o_rs2 = ex_rs2;
      end
      if (k == 2 && busy && (ex_addr !== t.rs1 || ex_rs2 !== t.rs2)) o_hold++;
      if (wb_en) begin
        o_wb++; o_rd = wb_rd; o_data = wb_data;
      end
      if (illegal_instr) o_ill++;
      if (timeout_err) o_tmo++;
      if (k != t.e_idle - 1 && (wb_data != 0 || wb_rd != 0)) o_stray++;
      if (instr_ready) begin
        o_idle = k;
        break;
      end
      ex_valid_out = (t.delay >= 0 && k == 2 + t.delay) || (t.early && k == 1);
      ex_result = ex_valid_out ? t.res : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    ex_valid_out = 1'b0;
    ex_result = '0;
  endtask
  task automatic verify(input vec_t t, input string tag);
    check({tag, ".issue"}, o_issue, t.e_issue);
    check({tag, ".ex_fields"}, 32'(o_ex), 32'(t.e_ex));
    check({tag, ".ex_addr"}, o_addr, t.e_issue != 0 ? t.rs1 : 32'h0);
    check({tag, ".ex_rs1"}, o_rs1, t.e_issue != 0 ? t.rs1 : 32'h0);
    check({tag, ".ex_rs2"}, o_rs2, t.e_issue != 0 ? t.rs2 : 32'h0);
    check({tag, ".hold"}, o_hold, 0);
    check({tag, ".wb_count"}, o_wb, t.e_wb);
    check({tag, ".wb_rd"}, 32'(o_rd), 32'(t.e_rd));
    check({tag, ".wb_data"}, o_data, t.e_data);
    check({tag, ".illegal"}, o_ill, t.e_ill);
    check({tag, ".timeout"}, o_tmo, t.e_tmo);
    check({tag, ".idle_cycle"}, o_idle, t.e_idle);
    check({tag, ".stray_wb"}, o_stray, 0);
  endtask
  initial begin
    logic [31:0] ops[3];
    int n_in, n_wb, viol, sent, bad;
    logic [4:0] last_rd;
    v[0] = '{32'h0020_A00B, 32'h0000_1000, 32'h0000_2000, 32'h0000_0055, 0, 1'b0, 1, 0, 5'd0, 32'h0, 0, 0, 4, {3'd2, 7'd0, 3'd0, 2'b00}};
    v[1] = '{32'hC632_528B, 32'h8000_0004, 32'h0000_00AB, 32'hCAFE_F00D, 10, 1'b0, 1, 1, 5'd5, 32'hCAFE_F00D, 0, 0, 14, {3'd5, 7'h63, 3'd6, 2'b11}};
    v[2] = '{32'h0020_81B3, 32'h0000_0005, 32'h0000_0006, 32'h0, 0, 1'b0, 0, 0, 5'd0, 32'h0, 1, 0, 1, 15'd0};
    v[3] = '{32'h0000_030B, 32'h1111_1111, 32'h2222_2222, 32'h0, -1, 1'b0, 1, 0, 5'd0, 32'h0, 0, 1, 66, 15'd0};
    v[4] = '{32'h0000_7F8B, 32'h0000_0003, 32'h0000_0004, 32'hFFFF_FFFF, 1, 1'b1, 1, 1, 5'd31, 32'hFFFF_FFFF, 0, 0, 5, {3'd7, 12'd0}};
    v[5] = '{32'h0000_008B, 32'h0000_0007, 32'h0000_0008, 32'h1234_5678, 62, 1'b0, 1, 1, 5'd1, 32'h1234_5678, 0, 0, 66, 15'd0};
    v[6] = '{32'h0000_010B, 32'h0000_0009, 32'h0000_000A, 32'h0BAD_F00D, 63, 1'b0, 1, 1, 5'd2, 32'h0BAD_F00D, 0, 0, 67, 15'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.instr_ready", 32'(instr_ready), 1);
    check("reset.quiet", 32'(quiet_bad()), 0);
    for (int i = 0; i < 7; i++) begin
      run_op(v[i]);
      verify(v[i], $sformatf("vec%0d", i));
    end
    @(negedge clk);
    instr_valid = 1'b1; instr = 32'h0000_038B; rs1_data = 32'h0000_AAAA; rs2_data = 32'h0000_BBBB;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid.busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_valid_out = 1'b1; ex_result = 32'h0000_0077;
    check("rst_mid.after_reset", 32'(quiet_bad()), 0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ex_valid_out = 1'b0;
      if (quiet_bad()) bad++;
    end
    check("rst_mid.quiet_after_pulse", bad, 0);
    run_op(v[1]);
    verify(v[1], "rst_mid.next");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ops[0] = 32'h0000_008B; ops[1] = 32'h0000_010B; ops[2] = 32'h0000_018B;
    n_in = 0; n_wb = 0; viol = 0; sent = 0; last_rd = '0;
    ex_valid_out = 1'b1; ex_result = 32'h0000_0099;
    instr_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (ex_valid_in) n_in++;
      if (wb_en) begin
        n_wb++; last_rd = wb_rd;
      end
      if (instr_ready == busy) viol++;
      if (instr_ready) begin
        if (sent < 3) begin
          instr = ops[sent]; sent++;
        end else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    ex_valid_out = 1'b0; instr_valid = 1'b0;
    check("b2b.ex_valid_in_strobes", n_in, 3);
    check("b2b.wb_count", n_wb, 3);
    check("b2b.last_rd", 32'(last_rd), 3);
    check("b2b.ready_vs_busy", viol, 0);
    check("b2b.idle_at_end", 32'(busy), 0);
`ifdef DISPATCH_PERF_EN
    check("b2b.perf_ops", perf_ops, 3);
    check("b2b.perf_wait", perf_wait, 3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
